// File: rtl/batch_accuracy.sv
// Streaming argmax scorer: compares per-row argmax of predictions against one-hot
// labels and presents the batch's correct-row count through a stb/ack handshake.
module batch_accuracy #(
    parameter int M  = 100,
    parameter int N  = 10,
    parameter int CW = $clog2(M + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   input_h,
    input  logic [31:0]   input_y,
    input  logic          input_stb,
    output logic          input_ack,
    output logic [CW-1:0] output_z,
    output logic          output_z_stb,
    input  logic          output_z_ack
);

    localparam int COLW = (N > 1) ? $clog2(N) : 1;
    localparam int ROWW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {S_INIT, S_ACCEPT, S_HOLD} state_t;

    // Monotonic unsigned key for IEEE-754 ordering (+0 above -0, NaNs by bit pattern).
    function automatic logic [31:0] fkey(input logic [31:0] x);
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

    state_t            state_q, state_d;
    logic [COLW-1:0]   col_q, col_d;
    logic [ROWW-1:0]   row_q, row_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       h_key_q, h_key_d, y_key_q, y_key_d;
    logic [COLW-1:0]   h_idx_q, h_idx_d, y_idx_q, y_idx_d;
    logic              input_ack_q, input_ack_d;
    logic [CW-1:0]     output_z_q, output_z_d;
    logic              output_z_stb_q, output_z_stb_d;

    logic              take;
    logic              h_new, y_new;
    logic [COLW-1:0]   h_idx_fin, y_idx_fin;
    logic [CW-1:0]     count_inc;

    // NOTE: every signal gets a default at the top of the block so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        count_d        = count_q;
        h_key_d        = h_key_q;
        y_key_d        = y_key_q;
        h_idx_d        = h_idx_q;
        y_idx_d        = y_idx_q;
        input_ack_d    = input_ack_q;
        output_z_d     = output_z_q;
        output_z_stb_d = output_z_stb_q;

        take      = input_stb && input_ack_q;
        h_new     = (col_q == '0) || (fkey(input_h) > h_key_q);
        y_new     = (col_q == '0) || (fkey(input_y) > y_key_q);
        h_idx_fin = h_new ? col_q : h_idx_q;
        y_idx_fin = y_new ? col_q : y_idx_q;
        count_inc = count_q + CW'(h_idx_fin == y_idx_fin);

        unique case (state_q)
            S_INIT: begin
                state_d     = S_ACCEPT;
                input_ack_d = 1'b1;
            end
            S_ACCEPT: begin
                if (take) begin
                    if (h_new) h_key_d = fkey(input_h);
                    if (y_new) y_key_d = fkey(input_y);
                    h_idx_d = h_idx_fin;
                    y_idx_d = y_idx_fin;
                    if (col_q == COLW'(N - 1)) begin
                        col_d   = '0;
                        row_d   = row_q + 1'b1;
                        count_d = count_inc;
                        if (row_q == ROWW'(M - 1)) begin
                            output_z_d     = count_inc;
                            output_z_stb_d = 1'b1;
                            input_ack_d    = 1'b0;
                            state_d        = S_HOLD;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (output_z_ack) begin
                    output_z_stb_d = 1'b0;
                    count_d        = '0;
                    row_d          = '0;
                    col_d          = '0;
                    input_ack_d    = 1'b1;
                    state_d        = S_ACCEPT;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_INIT;
            col_q          <= '0;
            row_q          <= '0;
            count_q        <= '0;
            h_key_q        <= '0;
            y_key_q        <= '0;
            h_idx_q        <= '0;
            y_idx_q        <= '0;
            input_ack_q    <= 1'b0;
            output_z_q     <= '0;
            output_z_stb_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            count_q        <= count_d;
            h_key_q        <= h_key_d;
            y_key_q        <= y_key_d;
            h_idx_q        <= h_idx_d;
            y_idx_q        <= y_idx_d;
            input_ack_q    <= input_ack_d;
            output_z_q     <= output_z_d;
            output_z_stb_q <= output_z_stb_d;
        end
    end

    assign input_ack    = input_ack_q;
    assign output_z     = output_z_q;
    assign output_z_stb = output_z_stb_q;

endmodule

// File: doc/batch_accuracy.md
# batch_accuracy

Streaming scorer placed downstream of the sigmoid stage of the logistic-regression trainer. Consumes one batch of predictions (sigmoid(h), M rows × N classes, IEEE-754 single) paired element-by-element with the one-hot label matrix y, takes the argmax of each prediction row and each label row, and counts the rows where they match. Presents the per-batch correct count through the same stb/ack handshake used by the matrix stages; the count drives the `rate` output and the success flag.

## Interface
Parameters:
- M, 100, rows per batch
- N, 10, classes per row
- CW, $clog2(M+1), count width (derived, do not override)

Ports:
- clk  input  1  system clock (100 MHz); single clock domain.
- rst  input  1  reset; asynchronous, active-high.
- input_h  input  32  prediction element, IEEE-754 single, row-major.
- input_y  input  32  label element, same position as input_h.
- input_stb  input  1  input_h/input_y valid.
- input_ack  output  1  block ready for an element pair. Registered.
- output_z  output  CW  correct-row count for the finished batch. Registered.
- output_z_stb  output  1  output_z valid. Registered.
- output_z_ack  input  1  downstream has taken output_z.

## Operation
- Transfer: one element pair is accepted on a rising clk when input_stb && input_ack. No other cycle changes the datapath.
- Order: row-major; column counter col (0..N-1), row counter row (0..M-1).
- Float ordering: key(x) = x[31] ? ~x : x ^ 32'h8000_0000; compare keys unsigned. Gives +0 > -0; NaNs are ordered by key, with no special handling.
- Running argmax per row, separately for h and y: at col==0 the element loads max/idx unconditionally. At col>0 the element replaces the current max only if its key is strictly greater. Ties therefore keep the lowest index.
- Row end, at the accepted element with col==N-1:
  - final idx includes that element.
  - if h_idx == y_idx, count += 1.
  - col clears; row increments.
- States:
  - INIT: input_ack=0. Lasts exactly one cycle after rst deasserts, then goes to ACCEPT.
  - ACCEPT: input_ack=1. On the row-end transfer with row==M-1:
    - output_z <= final count, including the last row.
    - output_z_stb <= 1, input_ack <= 0, state to HOLD.
  - HOLD: input_ack=0. output_z and output_z_stb are held stable. On output_z_ack=1:
    - output_z_stb <= 0.
    - count, row and col clear.
    - input_ack <= 1, state to ACCEPT.
- output_z_ack is ignored outside HOLD.
- Count saturation is impossible (at most M). CW is sized for the value M.
- Reset values: input_ack=0, output_z=0, output_z_stb=0, state=INIT, count/row/col=0.
- Reset asserted mid-batch or during HOLD: everything returns to the reset values immediately. The partial batch is discarded; there is no resume.
- input_stb low for any number of cycles stalls; counters and running max are held.

## Timing
- Throughput: 1 element pair per cycle in ACCEPT. One batch = M·N transfers, plus 1 handshake cycle.
- Latency: output_z_stb rises on the clock edge that accepts the last element (registered). It is visible the cycle after.
- Earliest next batch: input_ack returns to 1 in the cycle after the edge where output_z_ack was sampled high in HOLD.
- If output_z_ack is already high when output_z_stb rises, the handshake completes on the next edge. Minimum HOLD is 1 cycle.
- First acceptable transfer: 2nd rising edge after rst deasserts (INIT edge, then ACCEPT).

## Test plan
- Perfect batch (M=4, N=3): each h row peaks at the label's one-hot position (0.9 vs 0.1 values), input_stb held high -> output_z=4, and output_z_stb rises after exactly 12 transfers.
- Mixed batch (M=4, N=3): rows 1 and 3 peak at the wrong class -> output_z=2. With output_z_ack held low for 5 cycles: input_ack=0 and output_z stable throughout; after the ack, count=0 and input_ack=1 on the next cycle.
- Ties and signs (N=3):
  - h row {0.5, 0.5, 0.2} with label class 0 -> counted.
  - h row {-0.0, +0.0, -1.0} with label class 1 -> counted.
  - h row {-2.0, -1.0, -3.0} with label class 1 -> counted.
- Stalls: random input_stb gaps (up to 7 cycles) over a default-parameter batch -> same count as the no-gap golden model. No element is double-counted or dropped.
- Reset mid-batch: assert rst asynchronously (not clock-aligned) after 37 transfers -> outputs reach their reset values at once, input_ack=0 for one cycle after release. A following full batch scores only the new data.
- Back-to-back batches: output_z_ack tied high, two default batches with counts 100 and 0 -> output_z values are 100 then 0, each stb lasting 1 cycle.
